rr_stream_mux: RTL and testbench
================================

# rr_stream_mux

Parametrised N-channel stream multiplexer with a valid/ready handshake on every port, round-robin arbitration and a registered output stage. It generalises the fixed-select 2:1 and 4:1 index muxes to arbitrary channel count and data width. It adds flow control, a fair grant policy and a forced-select mode. It sits between independent data producers and a single downstream consumer.

## Interface
- `N_CH`, default 4: number of input channels, ≥ 2.
- `WIDTH`, default 4: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: width of channel indices (derived; not to be overridden).
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_valid` input, `N_CH` bits: per-channel valid.
- `in_ready` output, `N_CH` bits: per-channel ready; combinational.
- `in_data` input, `N_CH*WIDTH` bits: channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `force_en` input, 1 bit: 1 = only channel `force_sel` is eligible.
- `force_sel` input, `SEL_W` bits: forced channel index.
- `out_valid` output, 1 bit: output register holds a word.
- `out_ready` input, 1 bit: consumer accepts.
- `out_data` output, `WIDTH` bits: held word.
- `out_ch` output, `SEL_W` bits: source channel of the held word.

## Operation
- **State:** output register (`out_valid`, `out_data`, `out_ch`) plus round-robin pointer `ptr` (`SEL_W` bits, range 0..N_CH-1).
- **Load enable:** `load = !out_valid || out_ready`.
- **Eligible set:**
  - `force_en` = 0: all channels.
  - `force_en` = 1: only `force_sel`.
  - `force_sel` ≥ `N_CH` (non-power-of-two N_CH): no channel is eligible.
- **Grant `g`:** the first channel with `in_valid` asserted and eligible, searching `ptr, ptr+1, …` modulo `N_CH`. No grant if there is no such channel.
- **Ready:** `in_ready[g] = load` when a grant exists. Every other `in_ready` bit is 0. At most one bit is high per cycle.
- **Input transfer:** occurs on `in_valid[k] && in_ready[k]`. On that clock edge:
  - `out_data` ← channel k data.
  - `out_ch` ← k.
  - `out_valid` ← 1.
- **Output transfer:** occurs on `out_valid && out_ready`. If no input transfer happens in the same cycle, `out_valid` ← 0.
- **Simultaneous input and output transfer:** the register is replaced with the new word. `out_valid` stays 1, giving full throughput.
- **Pointer update:**
  - On an input transfer with `force_en` = 0: `ptr` ← `g+1`, wrapping `N_CH-1` → 0.
  - On forced transfers: `ptr` is unchanged.
- **Stall:** while `out_valid && !out_ready`, the following are all held:
  - `out_data`, `out_ch`, `out_valid`;
  - `ptr`;
  - all `in_ready` bits are 0.
- **Producer rule:** `in_valid` must not depend on `in_ready`. `in_ready` may depend on `in_valid`.
- **Producer obligation:** a producer holds `in_valid` and `in_data` stable until its transfer completes.

## Timing
- **Reset values:** `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0.
- **`in_ready` during reset:** forced to 0 while `rst` is high.
- **Latency:** 1 cycle. A word accepted at edge t is visible on `out_*` after edge t, and can be consumed in cycle t+1.
- **Throughput:** 1 word per cycle when `out_ready` is held high.
- **Fairness:** with all N_CH channels continuously valid and `force_en` = 0, grants follow the order 0,1,…,N_CH-1,0,… Each channel gets exactly one grant per N_CH transfers.
- **`force_en` changes:** take effect in the same cycle. No state is flushed.
- **Reset mid-operation:** a held output word is discarded. It is not re-presented after reset.

## Structure
- **Package `rr_stream_mux_pkg`** holds:
  - the function `rr_next(ptr, n)`, which increments with wrap;
  - the localparam helper for `SEL_W`.
- **Sub-module `rr_arbiter`:** combinational.
  - Parameter: `N_CH`.
  - Inputs: `req[N_CH]`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
  - Implementation: rotate by `ptr`, priority-encode, unrotate.
- **Top level:** instantiates `rr_arbiter` with `req = in_valid & eligible_mask`. It also holds the output register and `ptr`.

## Test plan
All scenarios use N_CH=4, WIDTH=4.
- **Reset:** assert `rst` for 2 cycles while `in_valid` = 4'b1111 → `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `in_ready` = 0. On the first cycle after reset, `in_ready` = 4'b0001.
- **Round-robin:** `in_valid` = 4'b1111, data 4'hA/B/C/D on channels 0–3, `out_ready` = 1 → `out_ch` sequence 0,1,2,3,0 with data A,B,C,D,A on consecutive cycles.
- **Wrap/skip:** `ptr` = 3, `in_valid` = 4'b0110 → grant 1, then `ptr` = 2, then next grant 2.
- **Backpressure:** word 4'h5 from channel 2 held, `out_ready` = 0 for 3 cycles → `out_data` stays 5, `in_ready` = 0 throughout. On `out_ready` = 1: the next word loads in the same cycle and `out_valid` stays 1.
- **Forced mode:** `force_en` = 1, `force_sel` = 2, `in_valid` = 4'b1111 → only channel 2 is granted on consecutive cycles, and `ptr` is unchanged. With `in_valid` = 4'b1011 → `in_ready` = 0 and `out_valid` falls after the held word is consumed.
- **Reset mid-stall:** `out_valid` = 1, `out_ready` = 0, then `rst` pulse → `out_valid` = 0 on the next cycle and the held word is never output.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg: shared helpers for the round-robin stream mux
package rr_stream_mux_pkg;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant via rotate, priority-encode, unrotate
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);
  localparam logic [SEL_W:0] NC = (SEL_W+1)'(N_CH);
  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0] rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0] sum;
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_CH];
  // lowest set bit of the rotated request is the first requester at or after ptr
  always_comb begin
    off = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    gnt_valid = |req;
    gnt_idx = (sum >= NC) ? SEL_W'(sum - NC) : sum[SEL_W-1:0];
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream mux with round-robin arbitration and registered output
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int WIDTH = 4,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  force_en,
  input  logic [SEL_W-1:0]      force_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch
);
  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0] eligible;
  logic gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic load, xfer;
  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
    .req(in_valid & eligible),
    .ptr(ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx)
  );
  // an out-of-range force_sel shifts the single bit out, leaving nothing eligible
  always_comb begin
    eligible = force_en ? (N_CH'(1) << force_sel) : '1;
    load = !out_valid || out_ready;
    xfer = !rst && gnt_valid && load;
    in_ready = xfer ? (N_CH'(1) << gnt_idx) : '0;
  end
  // output register and pointer; forced transfers leave the pointer alone
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_ch <= gnt_idx;
      if (!force_en) ptr <= SEL_W'(rr_next(int'(gnt_idx), N_CH));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed self-checking bench for rr_stream_mux
module tb_rr_stream_mux;
  logic clk = 0, rst = 1;
  logic [3:0] in_valid = 4'b1111, in_ready;
  logic [15:0] in_data;
  logic force_en = 0;
  logic [1:0] force_sel = 0;
  logic out_valid, out_ready = 1;
  logic [3:0] out_data;
  logic [1:0] out_ch;
  logic [3:0] d [4];
  int errors = 0, checks = 0;
  assign in_data = {d[3], d[2], d[1], d[0]};
  always #5 clk = ~clk;
  rr_stream_mux #(.N_CH(4), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .force_en(force_en), .force_sel(force_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic out_is(input string tag, input logic v, input logic [1:0] ch, input logic [3:0] dat);
    check({tag, "_v"}, 32'(out_valid), 32'(v));
    check({tag, "_ch"}, 32'(out_ch), 32'(ch));
    check({tag, "_d"}, 32'(out_data), 32'(dat));
  endtask
  initial begin
    d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
    tick();
    tick();
    out_is("reset", 0, 0, 0);
    check("reset_rdy", 32'(in_ready), 32'h0);
    rst = 0;
    #1 check("post_reset_rdy", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      out_is($sformatf("rr%0d", i), 1, 2'(i % 4), 4'(4'hA + i % 4));
    end
    in_valid = 4'b0100;
    tick();
    out_is("to_ptr3", 1, 2, 4'hC);
    in_valid = 4'b0110;
    #1 check("wrap_rdy", 32'(in_ready), 32'b0010);
    tick();
    out_is("wrap_g1", 1, 1, 4'hB);
    check("skip_rdy", 32'(in_ready), 32'b0100);
    tick();
    out_is("skip_g2", 1, 2, 4'hC);
    d[2] = 4'h5;
    in_valid = 4'b0100;
    tick();
    out_is("bp_load", 1, 2, 4'h5);
    out_ready = 0;
    #1 check("bp_rdy0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      out_is($sformatf("bp_hold%0d", i), 1, 2, 4'h5);
      check($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'h0);
    end
    in_valid = 4'b1000;
    out_ready = 1;
    #1 check("bp_release_rdy", 32'(in_ready), 32'b1000);
    tick();
    out_is("bp_next", 1, 3, 4'hD);
    d[2] = 4'hC;
    in_valid = 4'b1111;
    force_en = 1;
    force_sel = 2;
    #1 check("force_rdy", 32'(in_ready), 32'b0100);
    tick();
    out_is("force0", 1, 2, 4'hC);
    tick();
    out_is("force1", 1, 2, 4'hC);
    force_en = 0;
    #1 check("force_ptr_kept", 32'(in_ready), 32'b0001);
    force_en = 1;
    in_valid = 4'b1011;
    #1 check("force_none_rdy", 32'(in_ready), 32'h0);
    tick();
    check("force_drain_v", 32'(out_valid), 32'h0);
    force_en = 0;
    in_valid = 4'b0010;
    out_ready = 0;
    tick();
    out_is("stall_load", 1, 1, 4'hB);
    tick();
    out_is("stall_hold", 1, 1, 4'hB);
    rst = 1;
    tick();
    out_is("mid_reset", 0, 0, 0);
    check("mid_reset_rdy", 32'(in_ready), 32'h0);
    rst = 0;
    in_valid = 4'b0000;
    out_ready = 1;
    tick();
    check("no_represent", 32'(out_valid), 32'h0);
    in_valid = 4'b1111;
    #1 check("ptr_reset_rdy", 32'(in_ready), 32'b0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
